// File: rtl/mem_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_fifo_pkg
// Description : Shared constants and grant encoding for the memory FIFO
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_fifo_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic {
        GNT_WRITE = 1'b0,
        GNT_READ  = 1'b1
    } gnt_t;

endpackage : mem_fifo_pkg
`default_nettype wire

// File: rtl/mem_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_fifo_ctrl_if
// Description : Push/pop handshakes and memory bus of the FIFO controller.
//               MEM_FIFO_CTRL_THRESH_EN adds almost_full/almost_empty.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_fifo_ctrl_if;
    import mem_fifo_pkg::*;

    logic              push_valid;
    logic              push_ready;
    logic [DATA_W-1:0] push_data;
    logic              pop_valid;
    logic              pop_ready;
    logic [DATA_W-1:0] pop_data;
    logic [ADDR_W+1:0] level;
    logic              chip_en;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
`ifdef MEM_FIFO_CTRL_THRESH_EN
    logic              almost_full;
    logic              almost_empty;
`endif

    // master: the controller; slave: producer, consumer and memory around it
    modport master (
        input  push_valid, push_data, pop_ready, rd_data,
        output push_ready, pop_valid, pop_data, level,
               chip_en, wr_en, rd_en, addr, wr_data
`ifdef MEM_FIFO_CTRL_THRESH_EN
       ,output almost_full, almost_empty
`endif
    );

    modport slave (
        output push_valid, push_data, pop_ready, rd_data,
        input  push_ready, pop_valid, pop_data, level,
               chip_en, wr_en, rd_en, addr, wr_data
`ifdef MEM_FIFO_CTRL_THRESH_EN
       ,input  almost_full, almost_empty
`endif
    );

endinterface : mem_fifo_ctrl_if
`default_nettype wire

// File: rtl/mem_fifo_outbuf.sv
`default_nettype none
// ============================================================================
// Module      : mem_fifo_outbuf
// Description : Two-entry registered output buffer fed by memory read data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_fifo_outbuf
    import mem_fifo_pkg::*;
(
    input  wire logic              clock,
    input  wire logic              reset_n,
    input  wire logic              fill,
    input  wire logic [DATA_W-1:0] fill_data,
    input  wire logic              pop_ready,
    output logic                   pop_valid,
    output logic [DATA_W-1:0]      pop_data,
    output logic [1:0]             buf_cnt
);

    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic [1:0]        r_cnt;
    logic              w_pop;

    assign pop_valid = (r_cnt != 2'd0);
    assign pop_data  = r_head;
    assign buf_cnt   = r_cnt;
    assign w_pop     = pop_valid && pop_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case ({fill, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_head <= fill_data;
                    else               r_tail <= fill_data;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // head leaves while new data arrives: count unchanged
                    if (r_cnt == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= fill_data;
                    end else begin
                        r_head <= fill_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : mem_fifo_outbuf
`default_nettype wire

// File: rtl/mem_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_fifo_ctrl
// Description : Valid/ready FIFO on a single-port 1024x16 memory with
//               round-robin write/prefetch arbitration.
//               MEM_FIFO_CTRL_THRESH_EN adds almost_full/almost_empty.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_fifo_ctrl
    import mem_fifo_pkg::*;
`ifdef MEM_FIFO_CTRL_THRESH_EN
#(
    parameter int AF_LEVEL = 1020,
    parameter int AE_LEVEL = 2
)
`endif
(
    input  wire logic        clock,
    input  wire logic        reset_n,
    mem_fifo_ctrl_if.master  bus
);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_mem_cnt;
    logic              r_inflight;
    gnt_t              r_last_gnt;

    logic [1:0]        w_buf_cnt;
    logic              w_buf_valid;
    logic [DATA_W-1:0] w_buf_data;
    logic              w_rd_req;
    logic              w_wr_ok;
    logic              w_wr_req;
    logic              w_gnt_wr;
    logic              w_gnt_rd;
    logic              w_pop_fire;
    logic [ADDR_W+1:0] w_level;

    assign w_rd_req = (r_mem_cnt != '0) &&
                      (({1'b0, w_buf_cnt} + {2'b00, r_inflight}) < 3'd2);
    assign w_wr_ok  = (r_mem_cnt != (ADDR_W+1)'(DEPTH));
    assign w_wr_req = bus.push_valid && w_wr_ok;

    always_comb begin
        w_gnt_wr = 1'b0;
        w_gnt_rd = 1'b0;
        if (reset_n) begin
            if (w_rd_req && w_wr_req) begin
                if (r_last_gnt == GNT_WRITE) w_gnt_rd = 1'b1;
                else                         w_gnt_wr = 1'b1;
            end else begin
                w_gnt_rd = w_rd_req;
                w_gnt_wr = w_wr_req;
            end
        end
    end

    assign bus.wr_en      = w_gnt_wr;
    assign bus.rd_en      = w_gnt_rd;
    assign bus.chip_en    = w_gnt_wr | w_gnt_rd;
    assign bus.addr       = w_gnt_wr ? r_wr_ptr : (w_gnt_rd ? r_rd_ptr : '0);
    assign bus.wr_data    = w_gnt_wr ? bus.push_data : '0;
    // matches the arbiter: a pending read only loses when it was served last
    assign bus.push_ready = reset_n && w_wr_ok &&
                            (!w_rd_req || (r_last_gnt == GNT_READ));

    assign w_level      = {1'b0, r_mem_cnt} + {{(ADDR_W+1){1'b0}}, r_inflight} +
                          {{ADDR_W{1'b0}}, w_buf_cnt};
    assign bus.level    = reset_n ? w_level : '0;
    assign bus.pop_valid = reset_n && w_buf_valid;
    assign bus.pop_data = w_buf_data;
    assign w_pop_fire   = bus.pop_valid && bus.pop_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_inflight <= 1'b0;
            r_last_gnt <= GNT_READ;
        end else begin
            r_inflight <= w_gnt_rd;
            if (w_gnt_wr) begin
                r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
                r_mem_cnt  <= r_mem_cnt + (ADDR_W+1)'(1);
                r_last_gnt <= GNT_WRITE;
            end else if (w_gnt_rd) begin
                r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
                r_mem_cnt  <= r_mem_cnt - (ADDR_W+1)'(1);
                r_last_gnt <= GNT_READ;
            end
        end
    end

    mem_fifo_outbuf u_outbuf (
        .clock     (clock),
        .reset_n   (reset_n),
        .fill      (r_inflight),
        .fill_data (bus.rd_data),
        .pop_ready (bus.pop_ready),
        .pop_valid (w_buf_valid),
        .pop_data  (w_buf_data),
        .buf_cnt   (w_buf_cnt)
    );

`ifdef MEM_FIFO_CTRL_THRESH_EN
    logic              r_almost_full;
    logic              r_almost_empty;
    logic [ADDR_W+1:0] w_level_next;

    // reads only move entries between memory, flight and buffer
    assign w_level_next = w_level + (ADDR_W+2)'(w_gnt_wr) - (ADDR_W+2)'(w_pop_fire);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_level_next >= (ADDR_W+2)'(AF_LEVEL));
            r_almost_empty <= (w_level_next <= (ADDR_W+2)'(AE_LEVEL));
        end
    end

    assign bus.almost_full  = r_almost_full;
    assign bus.almost_empty = r_almost_empty;
`endif

endmodule : mem_fifo_ctrl
`default_nettype wire
